br_target_predictor: RTL and testbench

- Parametrised branch target buffer with per-entry saturating direction counters.
- Sits in the fetch stage of the pipelined MIPS datapath:
  - looked up combinationally with the current fetch PC;
  - trained by the branch-resolution logic in the MEM stage.
- Successor to the fixed 8-entry tagless predictor: generalises entry count, counter width and target width, and adds optional tag matching, allocate-on-taken policy and a synchronous table clear.

---
 rtl/br_target_predictor.sv | 132 +++++++++++++
 tb/tb_br_target_predictor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/br_target_predictor.sv
// br_target_predictor: direct-mapped branch target buffer with per-entry
// saturating direction counters. Looked up combinationally from the fetch PC,
// trained from the MEM-stage branch resolution.
// Optional feature macro: BTB_TAG_EN -- adds a per-entry tag so that aliasing
// PCs miss (and a taken alias replaces the entry) instead of sharing it.
module br_target_predictor #(
   parameter int ENTRIES = 8,
   parameter int CNT_W   = 2,
   parameter int TAG_W   = 8,
   parameter int WORD_W  = 32,
   localparam int IDX_W  = $clog2(ENTRIES)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WORD_W-1:0] lookup_pc,
   output logic              predict_hit,
   output logic              predict_taken,
   output logic [WORD_W-1:0] predict_target,
   output logic [IDX_W-1:0]  predict_idx,
   input  logic              upd_valid,
   input  logic [WORD_W-1:0] upd_pc,
   input  logic [IDX_W-1:0]  upd_idx,
   input  logic              upd_taken,
   input  logic [WORD_W-1:0] upd_target,
   input  logic              clear
);

   // Counter encoding: WNT is the clear/reset value, WT the allocate value.
   localparam int               CNT_WNT_I = (1 << (CNT_W - 1)) - 1;
   localparam int               CNT_WT_I  = 1 << (CNT_W - 1);
   localparam logic [CNT_W-1:0] CNT_WNT   = CNT_WNT_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_WT    = CNT_WT_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   // Table state
   logic [ENTRIES-1:0]             valid_q;
   logic [ENTRIES-1:0][CNT_W-1:0]  cnt_q;
   logic [ENTRIES-1:0][WORD_W-1:0] target_q;

   // Next-state of the single entry addressed by upd_idx
   logic              ent_we;
   logic [CNT_W-1:0]  ent_cnt_d;
   logic [WORD_W-1:0] ent_tgt_d;
   logic              upd_hit;
   logic              lk_hit;
   logic [IDX_W-1:0]  lk_idx;

   // Only the index (and, when compiled in, the tag) bits of the PCs matter.
   logic              unused_bits;
   localparam int     unused_tag_w = TAG_W;
   assign unused_bits = ^{lookup_pc, upd_pc};

`ifdef BTB_TAG_EN
   logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
   logic [TAG_W-1:0]              ent_tag_d;

   // Tag sits just above the index; PCs narrower than the tag zero-extend.
   function automatic logic [TAG_W-1:0] tag_of(input logic [WORD_W-1:0] pc);
      logic [WORD_W+TAG_W-1:0] ext;
      ext = {{TAG_W{1'b0}}, pc} >> (2 + IDX_W);
      return ext[TAG_W-1:0];
   endfunction

   assign lk_hit  = valid_q[lk_idx]  & (tag_q[lk_idx]  == tag_of(lookup_pc));
   assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == tag_of(upd_pc));
`else
   assign lk_hit  = valid_q[lk_idx];
   assign upd_hit = valid_q[upd_idx];
`endif

   // Lookup is purely combinational from the registered table.
   assign lk_idx         = lookup_pc[2 +: IDX_W];
   assign predict_idx    = lk_idx;
   assign predict_hit    = lk_hit;
   assign predict_taken  = lk_hit & cnt_q[lk_idx][CNT_W-1];
   assign predict_target = lk_hit ? target_q[lk_idx] : '0;

   // Training: saturating count on hit, allocate at WT on a taken miss.
   always_comb begin
      ent_we    = 1'b0;
      ent_cnt_d = cnt_q[upd_idx];
      ent_tgt_d = target_q[upd_idx];
`ifdef BTB_TAG_EN
      ent_tag_d = tag_q[upd_idx];
`endif
      if (upd_valid) begin
         if (upd_hit) begin
            ent_we = 1'b1;
            if (upd_taken) begin
               ent_cnt_d = (cnt_q[upd_idx] == CNT_MAX) ? CNT_MAX : cnt_q[upd_idx] + CNT_W'(1);
               ent_tgt_d = upd_target;
            end else begin
               ent_cnt_d = (cnt_q[upd_idx] == '0) ? '0 : cnt_q[upd_idx] - CNT_W'(1);
            end
         end else if (upd_taken) begin
            ent_we    = 1'b1;
            ent_cnt_d = CNT_WT;
            ent_tgt_d = upd_target;
`ifdef BTB_TAG_EN
            ent_tag_d = tag_of(upd_pc);
`endif
         end
      end
   end

   // Table registers: async reset, then clear, then the entry write.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid_q  <= '0;
         cnt_q    <= {ENTRIES{CNT_WNT}};
         target_q <= '0;
`ifdef BTB_TAG_EN
         tag_q    <= '0;
`endif
      end else if (clear) begin
         valid_q  <= '0;
         cnt_q    <= {ENTRIES{CNT_WNT}};
         target_q <= '0;
`ifdef BTB_TAG_EN
         tag_q    <= '0;
`endif
      end else if (ent_we) begin
         valid_q[upd_idx]  <= 1'b1;
         cnt_q[upd_idx]    <= ent_cnt_d;
         target_q[upd_idx] <= ent_tgt_d;
`ifdef BTB_TAG_EN
         tag_q[upd_idx]    <= ent_tag_d;
`endif
      end
   end

endmodule

// File: tb/tb_br_target_predictor.sv
// Self-checking bench for br_target_predictor (ENTRIES=8, CNT_W=2, TAG_W=8).
// A table-level model tracks the expected contents; a compare process checks
// every negedge, and directed steps pin literal values from the test plan.
module tb_br_target_predictor;

   localparam int E = 8;
   localparam int WT = 2;
   localparam int MAXC = 3;
   localparam int WNT = 1;

   logic        CLK, RST;
   logic [31:0] lookup_pc;
   logic        predict_hit, predict_taken;
   logic [31:0] predict_target;
   logic [2:0]  predict_idx;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [2:0]  upd_idx;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        clear;

   int n_pass = 0;
   int n_tot  = 0;

   br_target_predictor #(.ENTRIES(8), .CNT_W(2), .TAG_W(8), .WORD_W(32)) dut (
      .CLK(CLK), .RST(RST), .lookup_pc(lookup_pc),
      .predict_hit(predict_hit), .predict_taken(predict_taken),
      .predict_target(predict_target), .predict_idx(predict_idx),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx),
      .upd_taken(upd_taken), .upd_target(upd_target), .clear(clear)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- behavioural model ----------------
   bit          m_valid [E];
   int          m_cnt   [E];
   logic [31:0] m_tgt   [E];
   int          m_tag   [E];

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % E);
   endfunction

   function automatic int tag_of(input logic [31:0] pc);
      return int'((pc >> 5) % 256);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc, input int i);
`ifdef BTB_TAG_EN
      return m_valid[i] && (m_tag[i] == tag_of(pc));
`else
      return m_valid[i];
`endif
   endfunction

   always @(posedge CLK or posedge RST) begin
      if (RST || clear) begin
         for (int i = 0; i < E; i++) begin
            m_valid[i] = 0; m_cnt[i] = WNT; m_tgt[i] = 0; m_tag[i] = 0;
         end
      end else if (upd_valid) begin
         int i;
         i = int'(upd_idx);
         if (m_hit(upd_pc, i)) begin
            if (upd_taken) begin
               m_cnt[i] = (m_cnt[i] + 1 > MAXC) ? MAXC : m_cnt[i] + 1;
               m_tgt[i] = upd_target;
            end else begin
               m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
            end
         end else if (upd_taken) begin
            m_valid[i] = 1; m_cnt[i] = WT; m_tgt[i] = upd_target;
            m_tag[i] = tag_of(upd_pc);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Compare process: outputs are meaningful on every cycle.
   always @(negedge CLK) begin
      int  i;
      bit  h;
      i = idx_of(lookup_pc);
      h = m_hit(lookup_pc, i);
      chk("cmp_idx", {29'd0, predict_idx}, i);
      chk("cmp_hit", {31'd0, predict_hit}, {31'd0, h});
      chk("cmp_taken", {31'd0, predict_taken}, {31'd0, h && (m_cnt[i] >= WT)});
      chk("cmp_target", predict_target, h ? m_tgt[i] : 32'd0);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge CLK); #1;
      upd_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      upd_valid = 1'b1; upd_pc = pc; upd_idx = pc[4:2];
      upd_taken = tk; upd_target = tgt;
      tick();
   endtask

   task automatic look(input logic [31:0] pc);
      lookup_pc = pc; #1;
   endtask

   initial begin
      RST = 1'b1; clear = 1'b0; upd_valid = 1'b0; lookup_pc = 32'h40;
      upd_pc = '0; upd_idx = '0; upd_taken = 1'b0; upd_target = '0;
      #2;
      chk("rst_hit", {31'd0, predict_hit}, 0);
      chk("rst_taken", {31'd0, predict_taken}, 0);
      chk("rst_target", predict_target, 0);
      chk("rst_idx", {29'd0, predict_idx}, 0);
      tick(); tick();
      RST = 1'b0;
      tick();

      // first allocate
      upd(32'h40, 1'b1, 32'h100);
      look(32'h40);
      chk("alloc_hit", {31'd0, predict_hit}, 1);
      chk("alloc_taken", {31'd0, predict_taken}, 1);
      chk("alloc_target", predict_target, 32'h100);

      // saturation
      upd(32'h40, 1'b1, 32'h100); upd(32'h40, 1'b1, 32'h100);
      chk("model_cnt_sat", m_cnt[0], 3);
      upd(32'h40, 1'b0, 32'h0); look(32'h40);
      chk("nt1_taken", {31'd0, predict_taken}, 1);
      upd(32'h40, 1'b0, 32'h0); look(32'h40);
      chk("nt2_taken", {31'd0, predict_taken}, 0);
      upd(32'h40, 1'b0, 32'h0); upd(32'h40, 1'b0, 32'h0);
      chk("model_cnt_floor", m_cnt[0], 0);
      look(32'h40);
      chk("floor_hit", {31'd0, predict_hit}, 1);
      chk("floor_target", predict_target, 32'h100);
      upd(32'h40, 1'b1, 32'h100); look(32'h40);
      chk("model_cnt_one", m_cnt[0], 1);
      chk("one_taken", {31'd0, predict_taken}, 0);

      // aliasing
`ifdef BTB_TAG_EN
      look(32'h60);
      chk("alias_miss", {31'd0, predict_hit}, 0);
      upd(32'h60, 1'b1, 32'h200); look(32'h60);
      chk("alias_target", predict_target, 32'h200);
      look(32'h40);
      chk("alias_evict", {31'd0, predict_hit}, 0);
      upd(32'h40, 1'b1, 32'h100);
`else
      look(32'h60);
      chk("alias_hit", {31'd0, predict_hit}, 1);
      chk("alias_target", predict_target, 32'h100);
`endif

      // same-cycle update and lookup
      look(32'h40);
      upd_valid = 1'b1; upd_pc = 32'h40; upd_idx = 3'd0;
      upd_taken = 1'b1; upd_target = 32'h300; #1;
      chk("coinc_old", predict_target, 32'h100);
      tick();
      chk("coinc_new", predict_target, 32'h300);

      // clear wins over update
      clear = 1'b1;
      upd(32'h44, 1'b1, 32'h400);
      for (int i = 0; i < E; i++) begin
         look(32'(i * 4));
         chk("clear_hit", {31'd0, predict_hit}, 0);
      end

      // fill table, then async reset between edges
      tick();
      for (int i = 0; i < E; i++) upd(32'(i * 4), 1'b1, 32'(32'h1000 + i));
      look(32'h14);
      chk("fill_target", predict_target, 32'h1005);
      @(posedge CLK); #2;
      RST = 1'b1;
      for (int i = 0; i < E; i++) begin
         look(32'(i * 4));
         chk("arst_hit", {31'd0, predict_hit}, 0);
         chk("arst_target", predict_target, 0);
      end
      @(posedge CLK); #1;
      RST = 1'b0;
      upd(32'hC, 1'b1, 32'h500); look(32'hC);
      chk("model_cnt_wt", m_cnt[3], 2);
      chk("post_rst_taken", {31'd0, predict_taken}, 1);
      upd(32'hC, 1'b0, 32'h0); look(32'hC);
      chk("post_rst_wnt", {31'd0, predict_taken}, 0);

      // randomized traffic, checked by the compare process
      for (int n = 0; n < 400; n++) begin
         logic [31:0] pc;
         pc = 32'($urandom_range(0, 31)) << 2;
         lookup_pc = 32'($urandom_range(0, 31)) << 2;
         upd_valid = ($urandom_range(0, 3) != 0);
         upd_pc = pc; upd_idx = pc[4:2];
         upd_taken = $urandom_range(0, 1) == 1;
         upd_target = $urandom;
         clear = ($urandom_range(0, 49) == 0);
         @(posedge CLK); #1;
      end
      upd_valid = 1'b0; clear = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
